bank_packer: RTL and testbench
==============================

# bank_packer

Stream-to-bank packer that collects `BANK_SIZE` words of `WORD_SIZE` bits, arriving one per cycle over a valid/ready handshake, into a single packed bank word. It sits upstream of the adder tree and produces that block's `in` bus format. A short bank can be flushed early with `in_last`; its unused lanes are zero. A hold stage lets the next bank fill while the current bank waits for the consumer.

## Interface
- `WORD_SIZE`, 8: width of one input word.
- `BANK_SIZE`, 16: words per bank; must be ≥ 2.
- `CNT_W`, `$clog2(BANK_SIZE+1)`: width of `out_count`; a localparam, not overridable.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `in_valid` input 1: `in_data` / `in_last` valid.
- `in_ready` output 1: packer can accept a word this cycle.
- `in_data` input `WORD_SIZE`: word to pack.
- `in_last` input 1: this word closes the bank early; ignored when `in_valid` = 0.
- `out_valid` output 1: `out_data` / `out_count` hold a complete bank.
- `out_ready` input 1: consumer accepts the bank.
- `out_data` output `WORD_SIZE*BANK_SIZE`: packed bank; lane i is `[(i+1)*WORD_SIZE-1 : i*WORD_SIZE]`.
- `out_count` output `CNT_W`: number of filled lanes, 1..`BANK_SIZE`.

## Operation
- **Accept rule:** a word is accepted on a rising edge where `in_valid & in_ready`. The first accepted word of a bank goes to lane 0; each later word goes to the next lane.
- **Storage:**
  - Collect buffer, `BANK_SIZE` lanes.
  - Lane index `idx`, range 0..`BANK_SIZE`-1.
  - Output register: `out_data`, `out_count`, `out_valid`.
- **Bank complete:** an accepted word with `idx == BANK_SIZE-1` or `in_last = 1`.
- **States:**
  - **FILL:** `in_ready` = 1. When a bank completes:
    - If `~out_valid | out_ready`: in the same edge, move the collect buffer (including the completing word) to the output register, set `out_count` = `idx`+1, set `out_valid` = 1, clear the collect buffer to zero, set `idx` = 0. Stay in FILL.
    - Otherwise: keep the completed bank in the collect buffer with its count, and go to HOLD.
  - **HOLD:** `in_ready` = 0. On an edge with `out_ready = 1`, load the output register from the collect buffer, clear the buffer, set `idx` = 0, and go to FILL. `out_valid` stays 1 across this swap.
- **Output drain:** with `out_valid & out_ready` and no new bank loaded on that edge, `out_valid` goes to 0.
- **Stability:** while `out_valid & ~out_ready`, `out_data` and `out_count` hold stable.
- **Zero fill:** lanes at or above `out_count` are always zero.
- **No carry-over:** `in_last` never carries into the next bank. Lane 0 always starts the next bank.
- **Reset** (any time, including mid-bank or in HOLD):
  - Asynchronously clears the collect buffer, `idx`, and state (to FILL).
  - Clears `out_valid` = 0, `out_data` = 0, `out_count` = 0.
  - Any partial or pending bank is discarded.
  - `in_ready` = 1 while `rst_n` = 0 and after release.

## Timing
- **Latency:** the completing word accepted at edge N gives `out_valid` = 1 after edge N, when the output register is free or draining at N.
- **Throughput:** one word per cycle sustained when `out_ready` is held at 1. `in_ready` never drops in that case.
- **In HOLD:** `in_ready` is 0 from the edge after completion until the edge where `out_ready = 1` is sampled. `in_ready` returns to 1 after that edge.
- **Combinational paths:** `in_ready` is a function of registered state only. There is no combinational path from `out_ready` to `in_ready`.
- **Simultaneous events:**
  - Bank completion on the same edge as `out_valid & out_ready`: the new bank replaces the old one. `out_valid` stays 1 with no bubble.
  - `in_last` together with `idx == BANK_SIZE-1`: treated as a full bank, `out_count` = `BANK_SIZE`.
- **Output reset values:** `out_valid` 0, `out_data` 0, `out_count` 0, `in_ready` 1.

## Test plan
- **Full bank, no backpressure:** `out_ready` = 1; send words 1..16 on consecutive cycles.
  - One cycle after the 16th accept: `out_valid` = 1, lane i = i+1, `out_count` = 16.
  - `in_ready` stays 1 throughout.
- **Backpressure:** hold `out_ready` = 0; send 32 words, values 0x20..0x3F.
  - Bank 1 is shown on the output and stays stable.
  - `in_ready` = 0 after the 32nd accept.
  - Raise `out_ready` for one cycle: bank 2 (lane 0 = 0x30) appears on the next cycle, and `in_ready` returns to 1.
- **Early flush:** send 5 words, 0xA1..0xA5, with `in_last` on the 5th.
  - `out_count` = 5; lanes 0..4 = 0xA1..0xA5; lanes 5..15 = 0.
  - The next bank starts at lane 0.
- **Reset mid-fill:** accept 7 words, then pulse `rst_n` low asynchronously (not aligned to a clock edge).
  - All outputs take their reset values.
  - Sending 16 more words gives a bank whose lane 0 is the first post-reset word.
- **Streaming:** `out_ready` = 1; send 64 words, values 0..63.
  - Exactly 4 `out_valid` handshakes.
  - Bank k lane i = 16k+i.
  - No `in_ready` deassertion.
- **Corner case:** `in_last` asserted on the 16th word.
  - `out_count` = 16; a single bank is produced, identical to the full-bank case.

Source files
------------

// File: rtl/bank_packer.sv
// Stream-to-bank packer: gathers BANK_SIZE words into one packed bank word, with
// early flush on in_last and a hold stage so a finished bank can wait for the consumer.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
// The producer keeps valid/data stable until accepted; in_ready depends only on
// registered state, and out_data/out_count are stable while out_valid & ~out_ready.
module bank_packer #(
    parameter  int WORD_SIZE = 8,
    parameter  int BANK_SIZE = 16,
    localparam int CNT_W     = $clog2(BANK_SIZE + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WORD_SIZE-1:0]           in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_SIZE*BANK_SIZE-1:0] out_data,
    output logic [CNT_W-1:0]               out_count,
    output logic                           fsm_state
);

    localparam int IDX_W  = (BANK_SIZE > 1) ? $clog2(BANK_SIZE) : 1;
    localparam int BANK_W = WORD_SIZE * BANK_SIZE;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state;
    logic [BANK_W-1:0]   collect;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    hold_count;
    logic [BANK_W-1:0]   bank_next;
    logic [CNT_W-1:0]    fill_count;
    logic                accept;
    logic                last_lane;
    logic                complete;
    logic                out_free;

    assign in_ready   = (state == FILL);
    assign fsm_state  = state;
    assign accept     = in_valid & in_ready;
    assign last_lane  = (idx == IDX_W'(BANK_SIZE - 1));
    assign complete   = accept & (last_lane | in_last);
    assign out_free   = ~out_valid | out_ready;
    assign fill_count = CNT_W'(idx) + CNT_W'(1);

    // Collect buffer with the word accepted this cycle merged into its lane.
    always_comb begin
        bank_next = collect;
        if (accept) begin
            bank_next[idx*WORD_SIZE +: WORD_SIZE] = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            collect    <= '0;
            idx        <= '0;
            hold_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_count  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (complete && out_free) begin
                        out_data  <= bank_next;
                        out_count <= fill_count;
                        out_valid <= 1'b1;
                        collect   <= '0;
                        idx       <= '0;
                    end else begin
                        if (out_valid && out_ready) begin
                            out_valid <= 1'b0;
                        end
                        if (complete) begin
                            // Output still occupied: park the finished bank here.
                            collect    <= bank_next;
                            hold_count <= fill_count;
                            idx        <= '0;
                            state      <= HOLD;
                        end else if (accept) begin
                            collect <= bank_next;
                            idx     <= idx + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_data  <= collect;
                        out_count <= hold_count;
                        out_valid <= 1'b1;
                        collect   <= '0;
                        idx       <= '0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_packer.sv
// Directed bench for bank_packer: full, backpressure, flush, reset, streaming and corner banks.
module tb_bank_packer;

    localparam int W  = 8;
    localparam int B  = 16;
    localparam int BW = W * B;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic [4:0]    out_count;
    logic          fsm_state;

    int checks;
    int errors;
    logic [BW-1:0] exp_bank;

    bank_packer #(.WORD_SIZE(W), .BANK_SIZE(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .fsm_state (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at negedge, take effect on the next posedge; caller samples at the following negedge.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%0b count=%0d ready=%0b data=%h (want 0,0,1,0)",
                     out_valid, out_count, in_ready, out_data);
        end
    endtask

    task automatic test_full_bank(input logic last_on_16th, input string name);
        int ready_drops;
        ready_drops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < B; i++) begin
            if (in_ready !== 1'b1) ready_drops++;
            exp_bank[i*W +: W] = W'(i + 1);
            drive(1'b1, W'(i + 1), (i == B - 1) ? last_on_16th : 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 5'd16 || out_data !== exp_bank) begin
            errors++;
            $display("FAIL %s_bank: valid=%0b count=%0d data=%h want 1,16,%h",
                     name, out_valid, out_count, out_data, exp_bank);
        end
        checks++;
        if (ready_drops != 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: drops=%0d ready=%0b want 0,1", name, ready_drops, in_ready);
        end
        drive(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_single: out_valid=%0b want 0 after drain", name, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] exp2;
        out_ready = 1'b0;
        for (int i = 0; i < 2 * B; i++) begin
            if (i < B) exp_bank[i*W +: W] = W'(8'h20 + i);
            else       exp2[(i-B)*W +: W] = W'(8'h20 + i);
            drive(1'b1, W'(8'h20 + i), 1'b0);
            if (i == B + 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== exp_bank || out_count !== 5'd16) begin
                    errors++;
                    $display("FAIL bp_bank1_stable: valid=%0b count=%0d data=%h want 1,16,%h",
                             out_valid, out_count, out_data, exp_bank);
                end
            end
        end
        checks++;
        if (in_ready !== 1'b0 || out_data !== exp_bank) begin
            errors++;
            $display("FAIL bp_hold: ready=%0b data=%h want 0,%h", in_ready, out_data, exp_bank);
        end
        // A word offered while holding must be refused.
        drive(1'b1, 8'h99, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp2 || out_count !== 5'd16 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_bank2: valid=%0b count=%0d ready=%0b data=%h want 1,16,1,%h",
                     out_valid, out_count, in_ready, out_data, exp2);
        end
        out_ready = 1'b1;
        drive(1'b0, '0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%0b want 0", out_valid);
        end
    endtask

    task automatic test_early_flush();
        out_ready = 1'b1;
        exp_bank = '0;
        for (int i = 0; i < 5; i++) begin
            exp_bank[i*W +: W] = W'(8'hA1 + i);
            drive(1'b1, W'(8'hA1 + i), (i == 4));
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 5'd5 || out_data !== exp_bank) begin
            errors++;
            $display("FAIL flush_bank: valid=%0b count=%0d data=%h want 1,5,%h",
                     out_valid, out_count, out_data, exp_bank);
        end
        exp_bank = '0;
        exp_bank[0 +: W] = 8'hB1;
        exp_bank[W +: W] = 8'hB2;
        drive(1'b1, 8'hB1, 1'b0);
        drive(1'b1, 8'hB2, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_count !== 5'd2 || out_data !== exp_bank) begin
            errors++;
            $display("FAIL flush_next_lane0: valid=%0b count=%0d data=%h want 1,2,%h",
                     out_valid, out_count, out_data, exp_bank);
        end
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid_fill();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, W'(8'h70 + i), 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_async: valid=%0b count=%0d ready=%0b data=%h want 0,0,1,0",
                     out_valid, out_count, in_ready, out_data);
        end
        @(negedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < B; i++) begin
            exp_bank[i*W +: W] = W'(8'h50 + i);
            drive(1'b1, W'(8'h50 + i), 1'b0);
        end
        checks++;
        if (out_valid !== 1'b1 || out_count !== 5'd16 || out_data !== exp_bank) begin
            errors++;
            $display("FAIL mid_reset_bank: valid=%0b count=%0d data=%h want 1,16,%h",
                     out_valid, out_count, out_data, exp_bank);
        end
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_streaming();
        int hs;
        int bad;
        int drops;
        hs = 0;
        bad = 0;
        drops = 0;
        out_ready = 1'b1;
        for (int w = 0; w < 4 * B + 1; w++) begin
            if (in_ready !== 1'b1) drops++;
            if (w < 4 * B) drive(1'b1, W'(w), 1'b0);
            else           drive(1'b0, '0, 1'b0);
            if (out_valid === 1'b1) begin
                for (int i = 0; i < B; i++) exp_bank[i*W +: W] = W'(16 * hs + i);
                if (out_data !== exp_bank || out_count !== 5'd16) bad++;
                hs++;
            end
        end
        checks++;
        if (hs != 4 || bad != 0 || drops != 0) begin
            errors++;
            $display("FAIL streaming: handshakes=%0d bad_banks=%0d ready_drops=%0d want 4,0,0",
                     hs, bad, drops);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'(8'hC0 + i), 1'b1);
            exp_bank = '0;
            exp_bank[0 +: W] = W'(8'hC0 + i);
            if (out_valid !== 1'b1 || out_count !== 5'd1 || out_data !== exp_bank || in_ready !== 1'b1)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL back_to_back: bad_cycles=%0d want 0 (valid=%0b count=%0d data=%h)",
                     bad, out_valid, out_count, out_data);
        end
        drive(1'b0, '0, 1'b0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_bank  = '0;
        out_ready = 1'b0;
        test_reset();
        test_full_bank(1'b0, "full");
        test_backpressure();
        test_early_flush();
        test_reset_mid_fill();
        test_streaming();
        test_back_to_back();
        test_full_bank(1'b1, "last16");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
